priority_encoder_rr: RTL and testbench

//  Parametrised, registered N-input priority encoder with a valid/ready output handshake.

---
 rtl/priority_encoder_rr.sv | 99 +++++++++
 tb/tb_priority_encoder_rr.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_rr.sv
// Registered N-input priority encoder with valid/ready output handshake.
// MODE=0 picks the highest set index; MODE=1 rotates priority away from the last accepted winner.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no winner held; out_valid=0, grant=0, idx keeps last value
// ST_HOLD | winner held in idx/grant; out_valid=1 until out_ready
module priority_encoder_rr #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant,
    output logic         any_req
);

    localparam logic [0:0]   ST_IDLE = 1'b0;
    localparam logic [0:0]   ST_HOLD = 1'b1;
    localparam logic [N-1:0] ONE_HOT = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]   state;
    logic [W-1:0] last;
    logic [W-1:0] last_eff;
    logic [W-1:0] fixed_win;
    logic [W-1:0] low_win;
    logic [W-1:0] rr_win;
    logic [W-1:0] win;
    logic         low_hit;
    logic         any_live;
    logic         handshake;
    logic         load;

    assign any_live  = |req;
    assign handshake = (state == ST_HOLD) & out_ready;
    assign load      = en & any_live & ((state == ST_IDLE) | handshake);

    // A winner accepted on this edge already counts as "last" for the
    // back-to-back reload, so the rotation advances every cycle.
    assign last_eff = handshake ? idx : last;

    always_comb begin : fixed_pick
        fixed_win = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fixed_win = W'(i);
            end
        end
    end

    // Rotating order last-1 .. 0, N-1 .. last: the highest requester below
    // last wins; failing that, the highest requester overall (which is at or
    // above last). Only indices < N are ever examined.
    always_comb begin : rr_pick
        low_win = '0;
        low_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (W'(i) < last_eff)) begin
                low_win = W'(i);
                low_hit = 1'b1;
            end
        end
    end

    assign rr_win = low_hit ? low_win : fixed_win;
    assign win    = (MODE == 1) ? rr_win : fixed_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            grant   <= '0;
            any_req <= 1'b0;
            last    <= '0;
        end else begin
            any_req <= en & any_live;
            if (handshake) begin
                last <= idx;
            end
            if (load) begin
                state <= ST_HOLD;
                idx   <= win;
                grant <= ONE_HOT << win;
            end else if (handshake) begin
                state <= ST_IDLE;
                grant <= '0;
            end
        end
    end

    assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: fixed N=8, round-robin N=8 and N=5 instances
// checked against a behavioural model, directed tables/sequences and random traffic.
module tb_priority_encoder_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] req8 = '0;
    logic [4:0] req5 = '0;

    logic       va, vb, vc;
    logic [2:0] ia, ib, ic;
    logic [7:0] ga, gb;
    logic [4:0] gc;
    logic       aa, ab, ac;

    priority_encoder_rr #(.N(8), .MODE(0)) u_fix (
        .clk(clk), .rst(rst), .en(en), .req(req8), .out_ready(rdy),
        .out_valid(va), .idx(ia), .grant(ga), .any_req(aa)
    );
    priority_encoder_rr #(.N(8), .MODE(1)) u_rr8 (
        .clk(clk), .rst(rst), .en(en), .req(req8), .out_ready(rdy),
        .out_valid(vb), .idx(ib), .grant(gb), .any_req(ab)
    );
    priority_encoder_rr #(.N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst(rst), .en(en), .req(req5), .out_ready(rdy),
        .out_valid(vc), .idx(ic), .grant(gc), .any_req(ac)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state per instance: 0 = fixed/8, 1 = rr/8, 2 = rr/5
    int mv[3] = '{0, 0, 0};
    int mi[3] = '{0, 0, 0};
    int ml[3] = '{0, 0, 0};
    int ma[3] = '{0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_winner(input int n, input int mode, input int lst, input int rq);
        if (mode == 0) begin
            for (int i = n - 1; i >= 0; i--)
                if (rq[i]) return i;
        end else begin
            for (int s = 1; s <= n; s++) begin
                int c;
                c = (lst - s + n) % n;
                if (rq[c]) return c;
            end
        end
        return 0;
    endfunction

    task automatic model_step(input int k, input int n, input int mode, input int rq);
        int hs, ld, lst;
        if (rst) begin
            mv[k] = 0; mi[k] = 0; ml[k] = 0; ma[k] = 0;
            return;
        end
        hs    = (mv[k] != 0 && rdy) ? 1 : 0;
        lst   = hs ? mi[k] : ml[k];
        ld    = (en && rq != 0 && (mv[k] == 0 || hs)) ? 1 : 0;
        ma[k] = (en && rq != 0) ? 1 : 0;
        if (hs) ml[k] = mi[k];
        if (ld) begin
            mi[k] = ref_winner(n, mode, lst, rq);
            mv[k] = 1;
        end else if (hs) begin
            mv[k] = 0;
        end
    endtask

    function automatic int exp_grant(input int k);
        return mv[k] ? (1 << mi[k]) : 0;
    endfunction

    task automatic step();
        model_step(0, 8, 0, int'(req8));
        model_step(1, 8, 1, int'(req8));
        model_step(2, 5, 1, int'(req5));
        @(posedge clk);
        #1;
        check("fix.valid", 32'(va), 32'(mv[0]));
        check("fix.idx",   32'(ia), 32'(mi[0]));
        check("fix.grant", 32'(ga), 32'(exp_grant(0)));
        check("fix.any",   32'(aa), 32'(ma[0]));
        check("rr8.valid", 32'(vb), 32'(mv[1]));
        check("rr8.idx",   32'(ib), 32'(mi[1]));
        check("rr8.grant", 32'(gb), 32'(exp_grant(1)));
        check("rr8.any",   32'(ab), 32'(ma[1]));
        check("rr5.valid", 32'(vc), 32'(mv[2]));
        check("rr5.idx",   32'(ic), 32'(mi[2]));
        check("rr5.grant", 32'(gc), 32'(exp_grant(2)));
        check("rr5.any",   32'(ac), 32'(ma[2]));
        check("rr5.range", 32'(ic < 3'd5), 32'd1);
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] r8,
                         input logic [4:0] r5, input logic rd);
        rst = r; en = e; req8 = r8; req5 = r5; rdy = rd;
    endtask

    typedef struct {
        bit         r;
        bit         e;
        logic [7:0] rq;
        bit         rd;
        bit         ev;
        int         ei;
        int         eg;
        bit         ea;
    } vec_t;

    vec_t tbl[$];

    int seq4[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int seq5[7] = '{4, 0, 4, 0, 0, 0, 0};

    initial begin
        // fixed-mode directed vectors: inputs, then expected state after the edge
        tbl.push_back('{1, 1, 8'hFF, 0, 0, 0, 8'h00, 0});
        tbl.push_back('{1, 1, 8'hFF, 0, 0, 0, 8'h00, 0});
        tbl.push_back('{0, 1, 8'h2C, 1, 1, 5, 8'h20, 1});
        tbl.push_back('{0, 1, 8'h00, 1, 0, 5, 8'h00, 0});
        tbl.push_back('{0, 1, 8'h05, 0, 1, 2, 8'h04, 1});
        tbl.push_back('{0, 1, 8'h80, 0, 1, 2, 8'h04, 1});
        tbl.push_back('{0, 1, 8'h40, 0, 1, 2, 8'h04, 1});
        tbl.push_back('{0, 1, 8'h00, 0, 1, 2, 8'h04, 0});
        tbl.push_back('{0, 1, 8'h10, 0, 1, 2, 8'h04, 1});
        tbl.push_back('{0, 1, 8'h10, 1, 1, 4, 8'h10, 1});
        tbl.push_back('{0, 1, 8'h00, 1, 0, 4, 8'h00, 0});
        tbl.push_back('{0, 0, 8'hFF, 1, 0, 4, 8'h00, 0});
        tbl.push_back('{0, 1, 8'h08, 0, 1, 3, 8'h08, 1});
        tbl.push_back('{0, 0, 8'hFF, 0, 1, 3, 8'h08, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 3, 8'h08, 0});
        tbl.push_back('{0, 0, 8'hFF, 1, 0, 3, 8'h00, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].rq, tbl[i].rq[4:0], tbl[i].rd);
            step();
            check($sformatf("tbl%0d.valid", i), 32'(va), 32'(tbl[i].ev));
            check($sformatf("tbl%0d.idx", i),   32'(ia), 32'(tbl[i].ei));
            check($sformatf("tbl%0d.grant", i), 32'(ga), 32'(tbl[i].eg));
            check($sformatf("tbl%0d.any", i),   32'(aa), 32'(tbl[i].ea));
        end

        // round-robin N=8, all requesting, always ready
        drive(1, 0, 8'h00, 5'h00, 0);
        step();
        drive(0, 1, 8'hFF, 5'h1F, 1);
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("rr8.seq%0d", i), 32'(ib), 32'(seq4[i]));
            check($sformatf("rr8.seqv%0d", i), 32'(vb), 32'd1);
        end

        // round-robin N=5: two requesters alternate, then a sole requester repeats
        drive(1, 0, 8'h00, 5'h00, 0);
        step();
        drive(0, 1, 8'h00, 5'b10001, 1);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) req5 = 5'b00001;
            step();
            check($sformatf("rr5.seq%0d", i), 32'(ic), 32'(seq5[i]));
        end

        // reset on a handshake edge must not advance the rotation
        drive(1, 0, 8'h00, 5'h00, 0);
        step();
        drive(0, 1, 8'hFF, 5'h1F, 1);
        step();
        check("rr8.pre7", 32'(ib), 32'd7);
        step();
        check("rr8.pre6", 32'(ib), 32'd6);
        rst = 1'b1;
        step();
        check("rr8.rstv", 32'(vb), 32'd0);
        check("rr8.rsti", 32'(ib), 32'd0);
        rst = 1'b0;
        step();
        check("rr8.post", 32'(ib), 32'd7);

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 49) == 0);
            en   = ($urandom_range(0, 7) != 0);
            rdy  = ($urandom_range(0, 2) != 0);
            req8 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            req5 = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
